// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arbiter_pkg;

  localparam int CORE_ADDR_BUS_W = 14;
  localparam int CORE_DATA_BUS   = 32;
  localparam int MEM_WSTRB_W     = 4;

  typedef enum logic [1:0] {
    ARB_NONE = 2'd0,
    ARB_IMEM = 2'd1,
    ARB_DMEM = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Priority pick between fetch and load/store requesters.
// DMEM wins unless IMEM has been passed over D_STREAK_MAX times in a row.
module mem_arbiter_pick
  import mem_arbiter_pkg::*;
#(
  parameter int D_STREAK_MAX = 4
) (
  input  logic       imem_valid_i,
  input  logic       dmem_valid_i,
  input  logic [3:0] d_streak_i,
  input  logic       can_accept_i,
  output logic       grant_imem_o,
  output logic       grant_dmem_o
);

  localparam logic [3:0] STREAK_LIMIT = 4'(D_STREAK_MAX);

  logic imem_starved;

  // Priority decision; at most one grant, and only when a slot is free.
  always_comb begin
    imem_starved = imem_valid_i && (d_streak_i == STREAK_LIMIT);
    grant_dmem_o = can_accept_i && dmem_valid_i && !imem_starved;
    grant_imem_o = can_accept_i && imem_valid_i && !grant_dmem_o;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between fetch (IMEM) and
// load/store (DMEM). One transaction in flight, fixed read latency.
// Optional stall counters enabled by defining MEM_ARBITER_PERF_CNT_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT      = 1,
  parameter int D_STREAK_MAX = 4,
  parameter int AW           = CORE_ADDR_BUS_W,
  parameter int DW           = CORE_DATA_BUS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   imem_req_valid,
  output logic                   imem_req_ready,
  input  logic [AW-1:0]          imem_req_addr,
  output logic                   imem_rsp_valid,
  output logic [DW-1:0]          imem_rsp_data,
  input  logic                   dmem_req_valid,
  output logic                   dmem_req_ready,
  input  logic [AW-1:0]          dmem_req_addr,
  input  logic [DW-1:0]          dmem_req_wdata,
  input  logic [MEM_WSTRB_W-1:0] dmem_req_wstrb,
  output logic                   dmem_rsp_valid,
  output logic [DW-1:0]          dmem_rsp_data,
  output logic                   mem_en,
  output logic [MEM_WSTRB_W-1:0] mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  input  logic [DW-1:0]          mem_rdata
`ifdef MEM_ARBITER_PERF_CNT_EN
  ,
  output logic [31:0]            perf_imem_stall_cnt,
  output logic [31:0]            perf_dmem_stall_cnt
`endif
);

  localparam logic [2:0] LAST_CNT     = 3'(MEM_LAT - 1);
  localparam logic [3:0] STREAK_LIMIT = 4'(D_STREAK_MAX);

  arb_owner_t    owner_q, owner_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [3:0]    d_streak_q, d_streak_d;
  logic          store_q, store_d;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic rsp_fire, can_accept, grant_imem, grant_dmem, accept;

  // Response timing and slot availability; reset blocks new accepts.
  always_comb begin
    rsp_fire   = (owner_q != ARB_NONE) && (cnt_q == LAST_CNT);
    can_accept = rst_n && ((owner_q == ARB_NONE) || rsp_fire);
  end

  mem_arbiter_pick #(.D_STREAK_MAX(D_STREAK_MAX)) u_pick (
    .imem_valid_i (imem_req_valid),
    .dmem_valid_i (dmem_req_valid),
    .d_streak_i   (d_streak_q),
    .can_accept_i (can_accept),
    .grant_imem_o (grant_imem),
    .grant_dmem_o (grant_dmem)
  );

  // Memory-side drive and response routing. Write data only changes on a
  // DMEM grant since fetches carry none; otherwise the last value is held.
  always_comb begin
    accept         = grant_imem || grant_dmem;
    imem_req_ready = grant_imem;
    dmem_req_ready = grant_dmem;
    mem_en         = accept;
    mem_we         = '0;
    mem_addr       = addr_q;
    mem_wdata      = wdata_q;
    if (grant_dmem) begin
      mem_we    = dmem_req_wstrb;
      mem_addr  = dmem_req_addr;
      mem_wdata = dmem_req_wdata;
    end else if (grant_imem) begin
      mem_addr  = imem_req_addr;
    end
    imem_rsp_valid = rsp_fire && (owner_q == ARB_IMEM);
    imem_rsp_data  = imem_rsp_valid ? mem_rdata : '0;
    dmem_rsp_valid = rsp_fire && (owner_q == ARB_DMEM);
    dmem_rsp_data  = (dmem_rsp_valid && !store_q) ? mem_rdata : '0;
  end

  // Next-state: ownership, latency count and DMEM streak bookkeeping.
  always_comb begin
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    d_streak_d = d_streak_q;
    store_d    = store_q;
    if (accept) begin
      owner_d = grant_dmem ? ARB_DMEM : ARB_IMEM;
      cnt_d   = '0;
      store_d = grant_dmem && (dmem_req_wstrb != '0);
    end else if (rsp_fire) begin
      owner_d = ARB_NONE;
      cnt_d   = '0;
    end else if (owner_q != ARB_NONE) begin
      cnt_d = cnt_q + 3'd1;
    end
    if (grant_imem) begin
      d_streak_d = '0;
    end else if (grant_dmem) begin
      if (!imem_req_valid) begin
        d_streak_d = '0;
      end else if (d_streak_q != STREAK_LIMIT) begin
        d_streak_d = d_streak_q + 4'd1;
      end
    end
  end

  // State registers; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= ARB_NONE;
      cnt_q      <= '0;
      d_streak_q <= '0;
      store_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      d_streak_q <= d_streak_d;
      store_q    <= store_d;
      if (accept)     addr_q  <= mem_addr;
      if (grant_dmem) wdata_q <= dmem_req_wdata;
    end
  end

`ifdef MEM_ARBITER_PERF_CNT_EN
  logic [31:0] perf_imem_q, perf_dmem_q;

  // Stall counters: cycles a requester waits with valid high; wrap freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_imem_q <= '0;
      perf_dmem_q <= '0;
    end else begin
      if (imem_req_valid && !imem_req_ready) perf_imem_q <= perf_imem_q + 32'd1;
      if (dmem_req_valid && !dmem_req_ready) perf_dmem_q <= perf_dmem_q + 32'd1;
    end
  end

  assign perf_imem_stall_cnt = perf_imem_q;
  assign perf_dmem_stall_cnt = perf_dmem_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: two instances (MEM_LAT=1 and 3),
// directed/table vectors plus a randomized run against a cycle-number model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW  = 14;
  localparam int DW  = 32;
  localparam int NI  = 2;
  localparam int DSM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n [NI];
  logic          iv [NI], ir [NI], irv [NI];
  logic [AW-1:0] ia [NI];
  logic [DW-1:0] ird [NI];
  logic          dv [NI], dr [NI], drv [NI];
  logic [AW-1:0] da [NI];
  logic [DW-1:0] dwd [NI], drd [NI];
  logic [3:0]    dws [NI];
  logic          men [NI];
  logic [3:0]    mwe [NI];
  logic [AW-1:0] madr [NI];
  logic [DW-1:0] mwd [NI];
`ifdef MEM_ARBITER_PERF_CNT_EN
  logic [31:0]   pi_cnt [NI], pd_cnt [NI];
`endif

  int checks = 0;
  int errors = 0;

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return 32'hA000 + {18'd0, a};
  endfunction

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      logic [DW-1:0] pipe [3];
      logic [DW-1:0] rdata;

      mem_arbiter #(.MEM_LAT(gi == 0 ? 1 : 3), .D_STREAK_MAX(DSM)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n[gi]),
        .imem_req_valid (iv[gi]),
        .imem_req_ready (ir[gi]),
        .imem_req_addr  (ia[gi]),
        .imem_rsp_valid (irv[gi]),
        .imem_rsp_data  (ird[gi]),
        .dmem_req_valid (dv[gi]),
        .dmem_req_ready (dr[gi]),
        .dmem_req_addr  (da[gi]),
        .dmem_req_wdata (dwd[gi]),
        .dmem_req_wstrb (dws[gi]),
        .dmem_rsp_valid (drv[gi]),
        .dmem_rsp_data  (drd[gi]),
        .mem_en         (men[gi]),
        .mem_we         (mwe[gi]),
        .mem_addr       (madr[gi]),
        .mem_wdata      (mwd[gi]),
        .mem_rdata      (rdata)
`ifdef MEM_ARBITER_PERF_CNT_EN
        ,
        .perf_imem_stall_cnt (pi_cnt[gi]),
        .perf_dmem_stall_cnt (pd_cnt[gi])
`endif
      );

      // Memory model: read data appears MEM_LAT cycles after the strobe.
      always @(posedge clk) begin
        pipe[0] <= men[gi] ? data_of(madr[gi]) : 32'h0;
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
      end
      assign rdata = pipe[(gi == 0) ? 0 : 2];
    end
  endgenerate

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle(input int k);
    iv[k] = 1'b0; ia[k] = '0;
    dv[k] = 1'b0; da[k] = '0; dwd[k] = '0; dws[k] = '0;
  endtask

  task automatic do_reset(input int k);
    idle(k);
    @(negedge clk); rst_n[k] = 1'b0;
    @(negedge clk); rst_n[k] = 1'b1;
  endtask

  typedef struct {
    logic iv;
    logic dv;
    logic exp_ir;
    logic exp_dr;
  } vec_t;

  vec_t vecs [13];

  task automatic rand_run(input int k, input int ncyc);
    int lat = (k == 0) ? 1 : 3;
    bit ip = 0, dp = 0, has_out = 0, out_dm = 0, out_st = 0;
    bit fire, free, gd, gim;
    logic [AW-1:0] out_addr = '0, last_addr = '0;
    int fire_at = 0, streak = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (!ip && $urandom_range(0, 2) != 0) begin
        ip = 1; ia[k] = AW'($urandom);
      end
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = 1; da[k] = AW'($urandom); dwd[k] = $urandom;
        dws[k] = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      end
      iv[k] = ip; dv[k] = dp;
      #1;
      fire = has_out && (c == fire_at);
      free = !has_out || fire;
      gd   = free && dp && !(ip && streak == DSM);
      gim  = free && ip && !gd;
      chk("rnd_imem_ready", 32'(ir[k]), 32'(gim));
      chk("rnd_dmem_ready", 32'(dr[k]), 32'(gd));
      chk("rnd_mem_en", 32'(men[k]), 32'(gd || gim));
      chk("rnd_mem_we", 32'(mwe[k]), gd ? 32'(dws[k]) : 32'h0);
      chk("rnd_mem_addr", 32'(madr[k]), gd ? 32'(da[k]) : (gim ? 32'(ia[k]) : 32'(last_addr)));
      if (gd) chk("rnd_mem_wdata", mwd[k], dwd[k]);
      chk("rnd_imem_rsp_valid", 32'(irv[k]), 32'(fire && !out_dm));
      chk("rnd_dmem_rsp_valid", 32'(drv[k]), 32'(fire && out_dm));
      if (fire && !out_dm) chk("rnd_imem_rsp_data", ird[k], data_of(out_addr));
      if (fire && out_dm) chk("rnd_dmem_rsp_data", drd[k], out_st ? 32'h0 : data_of(out_addr));
      if (gd || gim)
        $display("rnd inst=%0d cyc=%0d grant=%s addr=%h we=%b", k, c, gd ? "D" : "I",
                 gd ? da[k] : ia[k], gd ? dws[k] : 4'h0);
      if (fire) has_out = 0;
      if (gd || gim) begin
        has_out   = 1;
        out_dm    = gd;
        out_st    = gd && (dws[k] != 4'h0);
        out_addr  = gd ? da[k] : ia[k];
        fire_at   = c + lat;
        last_addr = out_addr;
      end
      if (gim) begin streak = 0; ip = 0; end
      if (gd) begin
        streak = ip ? ((streak < DSM) ? streak + 1 : DSM) : 0;
        dp = 0;
      end
    end
    @(negedge clk); idle(k);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0};

    for (int k = 0; k < NI; k++) begin
      rst_n[k] = 1'b0;
      idle(k);
    end

    // Reset with both requesters active: nothing accepted.
    iv[0] = 1'b1; ia[0] = 14'h011;
    dv[0] = 1'b1; da[0] = 14'h033;
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst_imem_ready", 32'(ir[0]), 32'h0);
      chk("rst_dmem_ready", 32'(dr[0]), 32'h0);
      chk("rst_mem_en", 32'(men[0]), 32'h0);
      chk("rst_rsp_valid", 32'({irv[0], drv[0]}), 32'h0);
    end
    @(negedge clk); rst_n[0] = 1'b1; rst_n[1] = 1'b1; #1;
    chk("post_rst_dmem_grant", 32'(dr[0]), 32'h1);
    chk("post_rst_imem_ready", 32'(ir[0]), 32'h0);
    chk("post_rst_mem_en", 32'(men[0]), 32'h1);
    $display("reset release: dmem load 0x033 accepted");
    @(negedge clk); dv[0] = 1'b0; #1;
    chk("post_rst_dmem_rsp_valid", 32'(drv[0]), 32'h1);
    chk("post_rst_dmem_rsp_data", drd[0], 32'h0000A033);
    chk("post_rst_imem_grant", 32'(ir[0]), 32'h1);
    @(negedge clk); iv[0] = 1'b0; #1;
    chk("post_rst_imem_rsp_data", ird[0], 32'h0000A011);

    // MEM_LAT=1 fetch stream: one accept per cycle, data one cycle later.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      iv[0] = (i < 3);
      ia[0] = 14'h100 + 14'(i);
      #1;
      if (i < 3) begin
        chk("ifetch_ready", 32'(ir[0]), 32'h1);
        chk("ifetch_mem_addr", 32'(madr[0]), 32'h100 + 32'(i));
        chk("ifetch_mem_we", 32'(mwe[0]), 32'h0);
      end
      if (i > 0) begin
        chk("ifetch_rsp_valid", 32'(irv[0]), 32'h1);
        chk("ifetch_rsp_data", ird[0], 32'hA100 + 32'(i - 1));
        $display("ifetch rsp addr=%h data=%h", 14'h100 + 14'(i - 1), ird[0]);
      end
    end
    @(negedge clk); idle(0);

    // MEM_LAT=3 store then queued load, back-to-back at the fire cycle.
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 0) begin
        dv[1] = 1'b1; da[1] = 14'h020; dwd[1] = 32'hDEADBEEF; dws[1] = 4'b0011;
      end else if (c == 1) begin
        da[1] = 14'h021; dwd[1] = 32'h12345678; dws[1] = 4'b0000;
      end else if (c == 4) begin
        idle(1);
      end
      #1;
      case (c)
        0: begin
          chk("st_ready", 32'(dr[1]), 32'h1);
          chk("st_mem_we", 32'(mwe[1]), 32'h3);
          chk("st_mem_addr", 32'(madr[1]), 32'h20);
          chk("st_mem_wdata", mwd[1], 32'hDEADBEEF);
        end
        1, 2: begin
          chk("st_busy_ready", 32'(dr[1]), 32'h0);
          chk("st_busy_mem_en", 32'(men[1]), 32'h0);
          chk("st_busy_mem_we", 32'(mwe[1]), 32'h0);
          chk("st_busy_addr_hold", 32'(madr[1]), 32'h20);
          chk("st_busy_rsp", 32'(drv[1]), 32'h0);
        end
        3: begin
          chk("st_ack_valid", 32'(drv[1]), 32'h1);
          chk("st_ack_data", drd[1], 32'h0);
          chk("ld_b2b_ready", 32'(dr[1]), 32'h1);
          chk("ld_b2b_mem_addr", 32'(madr[1]), 32'h21);
          $display("store ack at 0x020, load 0x021 accepted same cycle");
        end
        4: begin
          chk("ld_wait_addr_hold", 32'(madr[1]), 32'h21);
          chk("ld_wait_wdata_hold", mwd[1], 32'h12345678);
          chk("ld_wait_rsp", 32'(drv[1]), 32'h0);
        end
        6: begin
          chk("ld_rsp_valid", 32'(drv[1]), 32'h1);
          chk("ld_rsp_data", drd[1], 32'h0000A021);
          $display("load rsp addr=021 data=%h", drd[1]);
        end
        default: chk("ld_wait_rsp", 32'(drv[1]), 32'h0);
      endcase
    end

    // Anti-starvation grant sequence from a cleared streak.
    do_reset(0);
    ia[0] = 14'h040; da[0] = 14'h050;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      iv[0] = vecs[i].iv; dv[0] = vecs[i].dv;
      #1;
      chk("vec_imem_ready", 32'(ir[0]), 32'(vecs[i].exp_ir));
      chk("vec_dmem_ready", 32'(dr[0]), 32'(vecs[i].exp_dr));
      chk("vec_mem_en", 32'(men[0]), 32'(vecs[i].exp_ir | vecs[i].exp_dr));
      $display("vec %0d iv=%b dv=%b imem_ready=%b dmem_ready=%b", i, iv[0], dv[0], ir[0], dr[0]);
    end
    @(negedge clk); idle(0);

    // Reset one cycle after a MEM_LAT=3 load is accepted.
    @(negedge clk); dv[1] = 1'b1; da[1] = 14'h030; #1;
    chk("rmid_accept", 32'(dr[1]), 32'h1);
    @(negedge clk); dv[1] = 1'b0; rst_n[1] = 1'b0; #1;
    chk("rmid_in_reset_rsp", 32'(drv[1]), 32'h0);
    @(negedge clk); rst_n[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      chk("rmid_no_rsp", 32'(drv[1]), 32'h0);
      chk("rmid_mem_en", 32'(men[1]), 32'h0);
    end
    @(negedge clk); iv[1] = 1'b1; ia[1] = 14'h007; #1;
    chk("rmid_free_after", 32'(ir[1]), 32'h1);
    @(negedge clk); idle(1);
    for (int c = 1; c < 4; c++) begin
      #1;
      chk("rmid_fetch_rsp_valid", 32'(irv[1]), 32'(c == 3));
      if (c == 3) chk("rmid_fetch_rsp_data", ird[1], 32'h0000A007);
      @(negedge clk);
    end
    $display("reset mid-op: dropped load, later fetch 0x007 served");

`ifdef MEM_ARBITER_PERF_CNT_EN
    // Stall counters while fetch waits behind DMEM traffic.
    do_reset(1);
    #1;
    chk("perf_rst_imem", pi_cnt[1], 32'h0);
    chk("perf_rst_dmem", pd_cnt[1], 32'h0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin dv[1] = 1'b1; da[1] = 14'h060; end
      if (c == 1) begin da[1] = 14'h062; iv[1] = 1'b1; ia[1] = 14'h061; end
      if (c == 4) dv[1] = 1'b0;
      if (c == 7) iv[1] = 1'b0;
      #1;
      if (c == 3) chk("perf_dmem_regrant", 32'(dr[1]), 32'h1);
      if (c == 6) begin
        chk("perf_imem_grant", 32'(ir[1]), 32'h1);
        chk("perf_imem_stalls", pi_cnt[1], 32'd5);
        chk("perf_dmem_stalls", pd_cnt[1], 32'd2);
      end
      if (c == 7) chk("perf_imem_stalls_hold", pi_cnt[1], 32'd5);
    end
    $display("perf: imem stalls=%0d dmem stalls=%0d", pi_cnt[1], pd_cnt[1]);
    repeat (4) @(negedge clk);
`endif

    // Randomized traffic against the reference model on both latencies.
    for (int k = 0; k < NI; k++) begin
      do_reset(k);
      rand_run(k, 300);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
